// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM.SS.CC stopwatch that feeds the 6-digit display driver.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    typedef struct packed {
        logic [6:0] mm;
        logic [5:0] ss;
        logic [6:0] cc;
    } sw_time_t;

    localparam logic [6:0]  CC_MAX           = 7'd99;
    localparam logic [5:0]  SS_MAX           = 6'd59;
    localparam logic [18:0] CNT_10MS_MAX_DEF = 19'd499_999;
    localparam logic [6:0]  MM_MAX_DEF       = 7'd99;
    localparam logic [5:0]  POINT_MASK_DEF   = 6'b010100;

    // Binary display word mm*10000 + ss*100 + cc; widened first so nothing truncates.
    function automatic logic [19:0] fmt_time(input sw_time_t t);
        return 20'(t.mm) * 20'd10000 + 20'(t.ss) * 20'd100 + 20'(t.cc);
    endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// 10 ms prescaler: counts while enabled, pulses tick on the wrap cycle, synchronous clear wins.
module sw_tick_gen
    import stopwatch_pkg::*;
#(
    parameter logic [18:0] CNT_MAX = CNT_10MS_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [18:0] cnt_q, cnt_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 19'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stopwatch_data_gen.sv
// MM.SS.CC stopwatch with start/pause, clear and lap-hold; produces registered display-driver inputs.
module stopwatch_data_gen
    import stopwatch_pkg::*;
#(
    parameter logic [18:0] CNT_10MS_MAX = CNT_10MS_MAX_DEF,
    parameter logic [6:0]  MM_MAX       = MM_MAX_DEF,
    parameter logic [5:0]  POINT_MASK   = POINT_MASK_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_start,
    input  logic        key_clear,
    input  logic        key_lap,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic        running
);

    sw_state_e   state_q, state_d;
    sw_time_t    time_q, time_d;
    sw_time_t    snap_q, snap_d;
    logic        hold_q, hold_d;
    logic [19:0] data_q, data_d;
    logic        running_q, running_d;
    logic [5:0]  point_q;
    logic        seg_en_q;
    logic        tick;
    logic        presc_clr;

    sw_tick_gen #(
        .CNT_MAX (CNT_10MS_MAX)
    ) u_tick_gen (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .en    (state_q == RUN),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        snap_d    = snap_q;
        hold_d    = hold_q;
        presc_clr = 1'b0;

        if (key_clear) begin
            state_d   = IDLE;
            time_d    = '0;
            hold_d    = 1'b0;
            presc_clr = 1'b1;
        end else begin
            // Tick only occurs in RUN; at 99:59.99 the fields saturate and the watch pauses.
            if (tick) begin
                if (time_q.cc != CC_MAX) begin
                    time_d.cc = time_q.cc + 7'd1;
                end else if (time_q.ss != SS_MAX) begin
                    time_d.cc = '0;
                    time_d.ss = time_q.ss + 6'd1;
                end else if (time_q.mm != MM_MAX) begin
                    time_d.cc = '0;
                    time_d.ss = '0;
                    time_d.mm = time_q.mm + 7'd1;
                end else begin
                    state_d = PAUSE;
                end
            end

            if (key_start) begin
                case (state_q)
                    IDLE: begin
                        state_d   = RUN;
                        presc_clr = 1'b1;
                    end
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end else if (key_lap) begin
                if (state_q == RUN) begin
                    hold_d = !hold_q;
                    if (!hold_q) snap_d = time_q;
                end else if (state_q == PAUSE && hold_q) begin
                    hold_d = 1'b0;
                end
            end
        end

        data_d    = fmt_time(hold_q ? snap_q : time_q);
        running_d = (state_d == RUN);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            time_q    <= '0;
            snap_q    <= '0;
            hold_q    <= 1'b0;
            data_q    <= '0;
            running_q <= 1'b0;
            point_q   <= '0;
            seg_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            snap_q    <= snap_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            running_q <= running_d;
            point_q   <= POINT_MASK;
            seg_en_q  <= 1'b1;
        end
    end

    assign data    = data_q;
    assign point   = point_q;
    assign sign    = 1'b0;
    assign seg_en  = seg_en_q;
    assign running = running_q;

endmodule

// File: tb/tb_stopwatch_data_gen.sv
// Self-checking bench: total-centisecond reference model compared every cycle, plus literal checkpoints.
module tb_stopwatch_data_gen;

    localparam logic [5:0] MASK = 6'b010100;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_start = 1'b0, key_clear = 1'b0, key_lap = 1'b0;
    logic o_start = 1'b0, o_clear = 1'b0, o_lap = 1'b0;
    logic [19:0] data, o_data;
    logic [5:0]  point, o_point;
    logic        sign, seg_en, running, o_sign, o_seg_en, o_running;

    int n_checks = 0;
    int n_pass = 0;

    always #5 sys_clk = ~sys_clk;

    stopwatch_data_gen #(
        .CNT_10MS_MAX (19'd9)
    ) dut (
        .sys_clk (sys_clk), .sys_rst_n (sys_rst_n),
        .key_start (key_start), .key_clear (key_clear), .key_lap (key_lap),
        .data (data), .point (point), .sign (sign), .seg_en (seg_en), .running (running)
    );

    // Second instance: one tick per clock and a 0-minute ceiling so saturation is reachable quickly.
    stopwatch_data_gen #(
        .CNT_10MS_MAX (19'd0),
        .MM_MAX       (7'd0)
    ) dut_ovf (
        .sys_clk (sys_clk), .sys_rst_n (sys_rst_n),
        .key_start (o_start), .key_clear (o_clear), .key_lap (o_lap),
        .data (o_data), .point (o_point), .sign (o_sign), .seg_en (o_seg_en), .running (o_running)
    );

    // Model works on elapsed centiseconds; st: 0 idle, 1 run, 2 pause.
    typedef struct packed {
        int st;
        int phase;
        int t;
        bit hold;
        int snap;
        int data;
        bit running;
        bit seg_en;
    } mdl_t;

    mdl_t m = '0;
    mdl_t mo = '0;

    function automatic int disp(input int cs);
        return (cs / 6000) * 10000 + ((cs / 100) % 60) * 100 + (cs % 100);
    endfunction

    function automatic mdl_t step(input mdl_t c, input bit kc, input bit ks, input bit kl,
                                  input int cnt_max, input int mm_max);
        mdl_t n = c;
        bit tk;
        n.data   = disp(c.hold ? c.snap : c.t);
        n.seg_en = 1'b1;
        if (kc) begin
            n.st = 0; n.t = 0; n.phase = 0; n.hold = 1'b0;
        end else begin
            tk = (c.st == 1) && (c.phase == cnt_max);
            if (c.st == 1) n.phase = tk ? 0 : c.phase + 1;
            if (tk) begin
                if (c.t == mm_max * 6000 + 5999) n.st = 2;
                else n.t = c.t + 1;
            end
            if (ks) begin
                if (c.st == 0) begin n.st = 1; n.phase = 0; end
                else n.st = (c.st == 1) ? 2 : 1;
            end else if (kl) begin
                if (c.st == 1) begin
                    n.hold = !c.hold;
                    if (!c.hold) n.snap = c.t;
                end else if (c.st == 2) begin
                    n.hold = 1'b0;
                end
            end
        end
        n.running = (n.st == 1);
        return n;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m  <= '0;
            mo <= '0;
        end else begin
            m  <= step(m, key_clear, key_start, key_lap, 9, 99);
            mo <= step(mo, o_clear, o_start, o_lap, 0, 0);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge sys_clk) begin
        check("model_data", data, m.data);
        check("model_flags", {point, sign, seg_en, running},
              {(m.seg_en ? MASK : 6'd0), 1'b0, m.seg_en, m.running});
        check("ovf_model_data", o_data, mo.data);
        check("ovf_model_flags", {o_point, o_sign, o_seg_en, o_running},
              {(mo.seg_en ? MASK : 6'd0), 1'b0, mo.seg_en, mo.running});
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse(input bit kc, input bit ks, input bit kl);
        key_clear = kc; key_start = ks; key_lap = kl;
        @(posedge sys_clk);
        #1;
        key_clear = 1'b0; key_start = 1'b0; key_lap = 1'b0;
    endtask

    task automatic pulse_ovf_start();
        o_start = 1'b1;
        @(posedge sys_clk);
        #1;
        o_start = 1'b0;
    endtask

    initial begin : ovf_seq
        wait (sys_rst_n === 1'b1);
        wait_clks(5);
        pulse_ovf_start();
        wait_clks(3000);
        check("ovf_mid_data", o_data, 2999);
        check("ovf_mid_running", o_running, 1);
        wait_clks(3000);
        check("ovf_sat_data", o_data, 5999);
        check("ovf_sat_running", o_running, 0);
        wait_clks(100);
        check("ovf_sat_hold", o_data, 5999);
        pulse_ovf_start();
        wait_clks(5);
        check("ovf_resume_data", o_data, 5999);
        check("ovf_resume_running", o_running, 0);
    end

    initial begin : main_seq
        int r;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_data", data, 0);
        check("rst_flags", {point, sign, seg_en, running}, 0);
        sys_rst_n = 1'b1;
        wait_clks(1);
        check("first_seg_en", seg_en, 1);
        check("first_point", point, MASK);
        wait_clks(49);
        check("idle_data", data, 0);
        check("idle_sign_running", {sign, running}, 0);

        pulse(0, 1, 0);
        wait_clks(3004);
        check("pre_lap", data, 300);
        pulse(0, 0, 1);
        wait_clks(999);
        check("lap_frozen", data, 300);
        pulse(0, 0, 1);
        check("lap_release_edge", data, 300);
        wait_clks(1);
        check("lap_released", data, 400);

        wait_clks(996);
        pulse(0, 1, 0);
        wait_clks(2000);
        check("paused_data", data, 500);
        check("paused_running", running, 0);
        pulse(0, 1, 0);
        wait_clks(7);
        check("resume_before", data, 500);
        wait_clks(1);
        check("resume_after", data, 501);

        wait_clks(7330);
        check("run_1234", data, 1234);
        check("run_running", running, 1);
        wait_clks(47659);
        check("run_5999", data, 5999);
        wait_clks(1);
        check("run_10000", data, 10000);

        pulse(1, 1, 0);
        check("clr_running", running, 0);
        wait_clks(1);
        check("clr_data", data, 0);
        wait_clks(20);
        check("clr_stays_idle", {data, running}, 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            key_clear = (r < 2) || (r >= 30 && r < 33);
            key_start = (r >= 2 && r < 10) || (r >= 30 && r < 36);
            key_lap   = (r >= 10 && r < 22) || (r >= 33 && r < 38);
            @(posedge sys_clk);
            #1;
        end
        key_clear = 1'b0; key_start = 1'b0; key_lap = 1'b0;

        pulse(1, 0, 0);
        pulse(0, 1, 0);
        wait_clks(257);
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1;
        check("async_rst_data", data, 0);
        check("async_rst_flags", {point, sign, seg_en, running}, 0);
        wait_clks(3);
        sys_rst_n = 1'b1;
        wait_clks(1);
        check("rerst_flags", {point, seg_en, running}, {MASK, 1'b1, 1'b0});
        pulse(0, 1, 0);
        wait_clks(10);
        check("rerst_no_partial", data, 0);
        wait_clks(1);
        check("rerst_first_tick", data, 1);

        wait_clks(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
